rbm_sequencer: RTL

- Synthesizable controller that drives the Main RBM datapath: hidden phase, then classifier phase, repeated ITER times.
- Generates pixel_id, hidden_id and spike_id indices; muxes weight/bias/pixel data from external combinational-read memories into Main.
- Captures Main's hidden results into an internal hidden buffer and accumulates spike counts per class.
- Sits between the model/image memories and Main, replacing bench-side sequencing in silicon builds.

---
 rtl/rbm_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/rbm_sequencer.sv
// Sequencer for the Main RBM datapath: hidden phase then classifier phase, ITER times per start.
// Optional macro RBM_SEQ_ARGMAX_EN adds out_class/class_valid (argmax over the class counters).
module rbm_sequencer #(
   parameter int N_VIS = 784,
   parameter int N_HID = 441,
   parameter int N_CLS = 10,
   parameter int W     = 64,
   parameter int ITER  = 1,
   parameter int CNT_W = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic [9:0]             pixel_id,
   output logic [8:0]             hidden_id,
   output logic [3:0]             spike_id,
   input  logic                   img_data,
   input  logic [W-1:0]           hw_data,
   input  logic [W-1:0]           hb_data,
   input  logic                   hsw_data,
   input  logic [W-1:0]           cw_data,
   input  logic [W-1:0]           cb_data,
   output logic                   pixel,
   output logic [W-1:0]           hvalue,
   output logic                   h_switch,
   output logic                   enable_hidden,
   output logic                   enable_classi,
   output logic                   hidden_pixel,
   output logic [W-1:0]           cvalue,
   input  logic                   hidden,
   input  logic                   spike,
`ifdef RBM_SEQ_ARGMAX_EN
   output logic [3:0]             out_class,
   output logic                   class_valid,
`endif
   output logic [N_CLS*CNT_W-1:0] out_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HID  = 2'd1;
   localparam logic [1:0] S_CLS  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [9:0]  PIX_BIAS  = 10'(N_VIS);
   localparam logic [8:0]  HID_LAST  = 9'(N_HID - 1);
   localparam logic [8:0]  HID_BIAS  = 9'(N_HID);
   localparam logic [3:0]  CLS_LAST  = 4'(N_CLS - 1);
   localparam logic [15:0] ITER_LAST = 16'(ITER - 1);

   logic [1:0]                    state;
   logic [15:0]                   iter;
   logic [N_HID-1:0]              hbuf;
   logic [N_CLS-1:0][CNT_W-1:0]   cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   assign busy      = (state == S_HID) || (state == S_CLS);
   assign done      = (state == S_DONE);
   assign out_count = cnt;

   // Bias slots are the index one past the last real element of each phase.
   assign pixel    = (pixel_id == PIX_BIAS) ? 1'b1 : img_data;
   assign hvalue   = (pixel_id == PIX_BIAS) ? hb_data : hw_data;
   assign h_switch = hsw_data;
   assign cvalue   = (hidden_id == HID_BIAS) ? cb_data : cw_data;

   always_comb begin
      hidden_pixel = 1'b1;
      for (int i = 0; i < N_HID; i++)
         if (hidden_id == 9'(i)) hidden_pixel = hbuf[i];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= S_IDLE;
         iter          <= '0;
         pixel_id      <= '0;
         hidden_id     <= '0;
         spike_id      <= '0;
         enable_hidden <= 1'b0;
         enable_classi <= 1'b0;
         hbuf          <= '0;
         cnt           <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               cnt           <= '0;
               iter          <= '0;
               pixel_id      <= '0;
               hidden_id     <= '0;
               spike_id      <= '0;
               enable_hidden <= 1'b1;
               state         <= S_HID;
            end
            S_HID: if (pixel_id == PIX_BIAS) begin
               for (int i = 0; i < N_HID; i++)
                  if (hidden_id == 9'(i)) hbuf[i] <= hidden;
               pixel_id <= '0;
               if (hidden_id != HID_LAST) begin
                  hidden_id <= hidden_id + 9'd1;
               end else begin
                  hidden_id     <= '0;
                  enable_hidden <= 1'b0;
                  enable_classi <= 1'b1;
                  state         <= S_CLS;
               end
            end else begin
               pixel_id <= pixel_id + 10'd1;
            end
            S_CLS: if (hidden_id == HID_BIAS) begin
               for (int c = 0; c < N_CLS; c++)
                  if (spike_id == 4'(c) && spike) cnt[c] <= sat_inc(cnt[c]);
               hidden_id <= '0;
               if (spike_id != CLS_LAST) begin
                  spike_id <= spike_id + 4'd1;
               end else if (iter != ITER_LAST) begin
                  // Straight back into the hidden phase, no idle cycle in between.
                  iter          <= iter + 16'd1;
                  spike_id      <= '0;
                  enable_classi <= 1'b0;
                  enable_hidden <= 1'b1;
                  state         <= S_HID;
               end else begin
                  enable_classi <= 1'b0;
                  state         <= S_DONE;
               end
            end else begin
               hidden_id <= hidden_id + 9'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef RBM_SEQ_ARGMAX_EN
   function automatic logic [3:0] argmax(input logic [N_CLS-1:0][CNT_W-1:0] c);
      logic [3:0]       best;
      logic [CNT_W-1:0] best_v;
      best   = '0;
      best_v = c[0];
      for (int i = 1; i < N_CLS; i++)
         if (c[i] > best_v) begin
            best_v = c[i];
            best   = 4'(i);
         end
      return best;
   endfunction

   always_ff @(posedge clock) begin
      if (reset)
         class_valid <= 1'b0;
      else if (state == S_IDLE && start)
         class_valid <= 1'b0;
      else if (state == S_CLS && hidden_id == HID_BIAS && spike_id == CLS_LAST && iter == ITER_LAST)
         class_valid <= 1'b1;
   end

   assign out_class = class_valid ? argmax(cnt) : 4'd0;
`endif

endmodule
